// File: rtl/seq_detect_driver.sv
// seq_detect_driver
//   Drives a serial Moore sequence detector (input w, registered output z).
//   An accepted start captures a PAT_W-bit pattern, clears the detector for
//   one cycle, then shifts the pattern into it MSB-first, one bit per clk.
//   Every cycle in which det_z reflects a shifted bit is sampled. det_z=1 in
//   such a cycle increments a saturating match counter.
//
//   Optional feature macro: PATTERN_LOOP_EN
//     Adds a 'loop' input. When loop=1 in the bit-0 SHIFT cycle, the pattern
//     is shifted again without clearing the detector. Without the macro the
//     controller behaves as if loop were tied low.
//
//   Handshake: start is a level request sampled on every rising clk edge
//   while busy=0 (IDLE). It is ignored while busy=1 and is never queued.
//   done pulses for exactly one cycle, in the IDLE cycle that follows DRAIN.
//   A start that is present in that cycle is accepted, which gives
//   back-to-back runs.
module seq_detect_driver #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
`ifdef PATTERN_LOOP_EN
  input  logic             loop,
`endif
  input  logic             det_z,
  output logic             det_w,
  output logic             det_reset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       state_dbg
);

  // Binary state encoding, kept stable so external checkers can decode state_dbg
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] CLEAR = 2'b01;
  localparam logic [1:0] SHIFT = 2'b10;
  localparam logic [1:0] DRAIN = 2'b11;

  localparam int              IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] idx_q;
  logic             first_q;   // first SHIFT cycle of a run: det_z still shows the cleared detector
  logic             done_q;
  logic [CNT_W-1:0] count_q;
  logic             loop_req;
  logic             sample;
  logic             last_bit;

`ifdef PATTERN_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  assign last_bit = (idx_q == '0);

  // det_z reflects the bit shifted in the previous cycle, so it is meaningful
  // in every SHIFT cycle except the first one after CLEAR, and once in DRAIN.
  assign sample = ((state_q == SHIFT) && !first_q) || (state_q == DRAIN);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = loop_req ? SHIFT : DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, pattern capture, bit index and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DRAIN);
      case (state_q)
        IDLE: begin
          if (start) pat_q <= pattern;
        end
        CLEAR: begin
          idx_q   <= LAST_IDX;
          first_q <= 1'b1;
        end
        SHIFT: begin
          first_q <= 1'b0;
          // On a loop pass the index wraps back to the MSB; otherwise DRAIN ignores it
          if (last_bit) idx_q <= LAST_IDX;
          else          idx_q <= idx_q - 1'b1;
        end
        default: begin
          first_q <= 1'b0;
        end
      endcase
    end
  end

  // Match counter: cleared on an accepted start, saturating increment on sampled det_z
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      count_q <= '0;
    end else if (sample && det_z && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_ONE;
    end
  end

  // Outputs: det_w is only driven from the captured copy during SHIFT
  always_comb begin
    det_w = 1'b0;
    if (state_q == SHIFT) det_w = pat_q[idx_q];
  end

  assign det_reset   = reset | (state_q == CLEAR);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign match_count = count_q;
  assign state_dbg   = state_q;

endmodule
